// File: rtl/sevenseg_pkg.sv
// =============================================================================
// sevenseg_pkg : shared segment constants and hex-to-segment table.  Rev 1.0
// =============================================================================
`default_nettype none

package sevenseg_pkg;

  localparam int SEG_W = 7;

  // Bit order of every segment vector, MSB first: {g,f,e,d,c,b,a}.
  typedef struct packed {
    logic g;
    logic f;
    logic e;
    logic d;
    logic c;
    logic b;
    logic a;
  } seg_bits_t;

  typedef logic [SEG_W-1:0] seg_t;

  localparam seg_t SEG_BLANK   = 7'b0;
  localparam int   MIN_CLK_DIV = 2;

  function automatic seg_t hex_to_seg(input logic [3:0] nib);
    seg_t seg;
    case (nib)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sevenseg_decoder.sv
// =============================================================================
// sevenseg_decoder : combinational hex decoder with ripple-blanking in/out.  Rev 1.0
// =============================================================================
`default_nettype none

module sevenseg_decoder
  import sevenseg_pkg::*;
(
  input  logic [3:0]       data,
  input  logic             rbi,
  output logic [SEG_W-1:0] segments,
  output logic             rbo
);

  always_comb begin
    segments = hex_to_seg(data);
    rbo      = 1'b0;
    if (rbi && (data == 4'h0)) begin
      segments = SEG_BLANK;
      rbo      = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sevenseg_scan.sv
// =============================================================================
// sevenseg_scan : multiplexed 7-segment scanner, double-buffered, zero blanking.
// Optional SEVENSEG_BLANK_GAP_EN inserts a one-cycle dark gap per digit.  Rev 1.0
// =============================================================================
`default_nettype none

module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int CLK_DIV = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic                  blank_en,
  output logic [SEG_W-1:0]      segments,
  output logic [DIGITS-1:0]     digit_en,
  output logic                  frame_done
);

  localparam int DIV_N = (CLK_DIV < MIN_CLK_DIV) ? MIN_CLK_DIV : CLK_DIV;
  localparam int DIV_W = $clog2(DIV_N);
  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_N - 1);
  localparam logic [IDX_W-1:0] IDX_MSD  = IDX_W'(DIGITS - 1);

  logic [DIV_W-1:0]    div_q, div_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [4*DIGITS-1:0] pending_q, pending_d;
  logic                pend_valid_q, pend_valid_d;
  logic                blank_frame_q, blank_frame_d;
  logic                rbo_q, rbo_d;
  logic [SEG_W-1:0]    segments_q, segments_d;
  logic [DIGITS-1:0]   digit_en_q, digit_en_d;
  logic                frame_done_q, frame_done_d;

  logic                tick;
  logic                frame_end;
  logic                msd_start;
  logic [3:0]          nib;
  logic                dec_rbi;
  logic                dec_rbo;
  logic [SEG_W-1:0]    dec_seg;

  assign tick      = (div_q == DIV_LAST);
  assign frame_end = tick && (idx_q == '0);
  assign msd_start = (idx_q == IDX_MSD) && (div_q == '0);
  assign nib       = shadow_q[{idx_q, 2'b00} +: 4];

  // The MSD uses blank_en live in its first cycle, then the value latched then.
  always_comb begin
    if (idx_q == IDX_MSD) begin
      dec_rbi = msd_start ? blank_en : blank_frame_q;
    end else if (idx_q == '0) begin
      dec_rbi = 1'b0;
    end else begin
      dec_rbi = rbo_q;
    end
  end

  sevenseg_decoder u_dec (
    .data     (nib),
    .rbi      (dec_rbi),
    .segments (dec_seg),
    .rbo      (dec_rbo)
  );

  always_comb begin
    div_d         = tick ? '0 : div_q + 1'b1;
    idx_d         = idx_q;
    if (tick) begin
      idx_d = (idx_q == '0) ? IDX_MSD : idx_q - 1'b1;
    end
    rbo_d         = tick ? dec_rbo : rbo_q;
    blank_frame_d = msd_start ? blank_en : blank_frame_q;

    pending_d     = load ? value : pending_q;
    pend_valid_d  = load | pend_valid_q;
    shadow_d      = shadow_q;
    // A load landing on the frame-end tick bypasses the pending stage.
    if (frame_end) begin
      if (load) begin
        shadow_d = value;
      end else if (pend_valid_q) begin
        shadow_d = pending_q;
      end
      pend_valid_d = 1'b0;
    end

    frame_done_d  = frame_end;
    digit_en_d    = DIGITS'(1) << idx_q;
    segments_d    = dec_seg;
`ifdef SEVENSEG_BLANK_GAP_EN
    if (div_q == '0) begin
      digit_en_d = '0;
      segments_d = SEG_BLANK;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q         <= '0;
      idx_q         <= IDX_MSD;
      shadow_q      <= '0;
      pending_q     <= '0;
      pend_valid_q  <= 1'b0;
      blank_frame_q <= 1'b0;
      rbo_q         <= 1'b0;
      segments_q    <= SEG_BLANK;
      digit_en_q    <= '0;
      frame_done_q  <= 1'b0;
    end else begin
      div_q         <= div_d;
      idx_q         <= idx_d;
      shadow_q      <= shadow_d;
      pending_q     <= pending_d;
      pend_valid_q  <= pend_valid_d;
      blank_frame_q <= blank_frame_d;
      rbo_q         <= rbo_d;
      segments_q    <= segments_d;
      digit_en_q    <= digit_en_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign segments   = segments_q;
  assign digit_en   = digit_en_q;
  assign frame_done = frame_done_q;

endmodule

`default_nettype wire
